ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter CTRL_W, default 8: width of one control word (RegWrite, MemWrite, MemtoReg, ALUSrc, ALU op, PCSrc, ...).
REQ-002 Parameter NUM_STAGES, default 3: number of control pipeline stages after decode (EX, MEM, WB); legal range 2..8.
REQ-003 Parameter FLUSH_DEPTH, default 2: number of youngest stages cleared by flush; legal range 1..NUM_STAGES.
REQ-004 Parameter KEEP_MASK, NUM_STAGES*CTRL_W bits, default all ones: per-stage mask of control bits carried into that stage; stage k uses slice [k*CTRL_W +: CTRL_W].
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-007 ctrl_in  input  CTRL_W  decoded control word from the control unit.
REQ-008 valid_in  input  1  ctrl_in carries a real instruction.
REQ-009 nop_sel  input  1  force a bubble in place of ctrl_in (control mux select).
REQ-010 stall_in  input  1  hold stage 0 and insert a bubble into stage 1.
REQ-011 flush_in  input  1  squash stages 0..FLUSH_DEPTH-1.
REQ-012 ready_out  output  1  combinational; equals NOT stall_in OR flush_in; 1 = ctrl_in consumed at the next edge.
REQ-013 ctrl_out  output  NUM_STAGES*CTRL_W  registered control word of every stage; stage k in slice k.
REQ-014 valid_out  output  NUM_STAGES  registered valid bit per stage.
REQ-015 bubble_cnt  output  16  saturating count of bubbles retired from the last stage.

Function
REQ-016 A bubble SHALL be valid=0 with an all-zero control word; an invalid stage never drives a nonzero ctrl_out slice.
REQ-017 Entry word SHALL be ctrl_in & mask0 with valid=1 when valid_in=1 and nop_sel=0; otherwise a bubble.
REQ-018 Normal advance (stall_in=0, flush_in=0): stage 0 loads the entry word; stage k (k>=1) loads stage k-1 word & mask_k and stage k-1 valid.
REQ-019 Latency: a word accepted at edge n SHALL be visible in stage k after edge n+k (stage 0 after edge n).
REQ-020 Stall (stall_in=1, flush_in=0): stage 0 holds word and valid; stage 1 loads a bubble; stages >=2 advance per REQ-018; ctrl_in is not consumed.
REQ-021 Flush (flush_in=1): stages 0..FLUSH_DEPTH-1 load bubbles, discarding ctrl_in; stages >=FLUSH_DEPTH advance from pre-edge values per REQ-018.
REQ-022 Flush SHALL take priority over stall when both are asserted in the same cycle; stall is ignored.
REQ-023 nop_sel with stall_in and no flush: stall behaviour; nop_sel has no effect since ctrl_in is not consumed.
REQ-024 Repeated stall cycles SHALL hold stage 0 indefinitely and inject one bubble into stage 1 per cycle.
REQ-025 bubble_cnt SHALL increment by 1 at every edge where the pre-edge valid of the last stage is 0, and hold at 16'hFFFF once reached (no wrap).
REQ-026 Masking SHALL be cumulative: a bit cleared in mask_k stays cleared in all stages beyond k.

Reset
REQ-027 reset=0 SHALL immediately clear all ctrl_out slices, all valid_out bits and bubble_cnt to zero, regardless of clk.
REQ-028 While reset=0, no state SHALL update; ready_out remains combinational per REQ-012.
REQ-029 First edge after reset deassertion SHALL behave as a normal cycle per REQ-018..REQ-022; reset mid-stall or mid-flush discards all in-flight words.

Verification
REQ-030 Stream 0xA5, 0x3C, 0xFF with valid_in=1 on 3 consecutive edges (defaults) -> stage 2 shows 0xA5, 0x3C, 0xFF after edges 3, 4, 5; valid_out=3'b111 after edge 3.
REQ-031 KEEP_MASK stage 1 = 0x0F, input 0xA5 -> stage 1 = 0x05, stage 2 = 0x05.
REQ-032 Stage 0 = 0xA5; stall_in=1 for 2 edges -> ready_out=0; stage 0 stays 0xA5; stage 1 = 0x00 with valid 0 on both edges; 0xA5 reaches stage 2 two edges late.
REQ-033 Stages hold 0x11/0x22/0x33, flush_in=1 and stall_in=1 with FLUSH_DEPTH=2 -> after edge: stage0=0, stage1=0, stage2=0x22, valid_out=3'b100.
REQ-034 reset=0 asserted between edges with pipeline full -> all outputs 0 before the next edge; release and feed 0x5A -> stage 0 = 0x5A after one edge.
REQ-035 valid_in=0 for 65540 edges after reset -> bubble_cnt reaches 16'hFFFF and holds; first valid word does not change it.

Source files
------------

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control-word pipeline (EX/MEM/WB) with stall, flush, per-stage masking
// and a saturating retired-bubble counter.
module ctrl_pipe #(
  parameter int CTRL_W      = 8,
  parameter int NUM_STAGES  = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter logic [NUM_STAGES*CTRL_W-1:0] KEEP_MASK = '1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CTRL_W-1:0]            ctrl_in,
  input  logic                         valid_in,
  input  logic                         nop_sel,
  input  logic                         stall_in,
  input  logic                         flush_in,
  output logic                         ready_out,
  output logic [NUM_STAGES*CTRL_W-1:0] ctrl_out,
  output logic [NUM_STAGES-1:0]        valid_out,
  output logic [15:0]                  bubble_cnt
);

  logic [NUM_STAGES-1:0][CTRL_W-1:0] keep;
  logic [NUM_STAGES-1:0][CTRL_W-1:0] word_q;
  logic [NUM_STAGES-1:0][CTRL_W-1:0] word_d;
  logic [NUM_STAGES-1:0][CTRL_W-1:0] prev_w;
  logic [NUM_STAGES-1:0]             vld_q;
  logic [NUM_STAGES-1:0]             vld_d;
  logic [NUM_STAGES-1:0]             prev_v;
  logic                              take;

  assign keep      = KEEP_MASK;
  assign take      = valid_in & ~nop_sel;
  assign ready_out = ~stall_in | flush_in;
  assign ctrl_out  = word_q;
  assign valid_out = vld_q;

  // prev_* is what each stage would load on a plain advance; a rejected entry is an all-zero bubble
  assign prev_w = {word_q[NUM_STAGES-2:0], {CTRL_W{take}} & ctrl_in};
  assign prev_v = {vld_q[NUM_STAGES-2:0], take};

  always_comb begin
    word_d = '0;
    vld_d  = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      word_d[k] = prev_w[k] & keep[k];
      vld_d[k]  = prev_v[k];
    end
    if (flush_in) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (k < FLUSH_DEPTH) begin
          word_d[k] = '0;
          vld_d[k]  = 1'b0;
        end
      end
    end else if (stall_in) begin
      word_d[0] = word_q[0];
      vld_d[0]  = vld_q[0];
      word_d[1] = '0;
      vld_d[1]  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q     <= '0;
      vld_q      <= '0;
      bubble_cnt <= '0;
    end else begin
      word_q <= word_d;
      vld_q  <= vld_d;
      if (!vld_q[NUM_STAGES-1] && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - randomized and directed bench for ctrl_pipe against a rule-level model
// (one default instance, one with stage-1 mask 0x0F).
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  ctrl_in = '0;
  logic        valid_in = 1'b0;
  logic        nop_sel = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        ready_out [2];
  logic [23:0] ctrl_out [2];
  logic [2:0]  valid_out [2];
  logic [15:0] bubble_cnt [2];

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  mw [2][3];
  logic        mv [2][3];
  logic [15:0] mc [2];
  logic [7:0]  msk [2][3];

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in), .nop_sel(nop_sel),
    .stall_in(stall_in), .flush_in(flush_in), .ready_out(ready_out[0]), .ctrl_out(ctrl_out[0]),
    .valid_out(valid_out[0]), .bubble_cnt(bubble_cnt[0])
  );

  ctrl_pipe #(.KEEP_MASK(24'hFF0FFF)) dut_m (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in), .nop_sel(nop_sel),
    .stall_in(stall_in), .flush_in(flush_in), .ready_out(ready_out[1]), .ctrl_out(ctrl_out[1]),
    .valid_out(valid_out[1]), .bubble_cnt(bubble_cnt[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mc[d] = '0;
      for (int k = 0; k < 3; k++) begin
        mw[d][k] = '0;
        mv[d][k] = 1'b0;
      end
    end
  endtask

  // One clock edge of the pipeline rules, using the inputs held across the edge.
  task automatic model_step();
    logic [7:0] ow [3];
    logic       ov [3];
    if (!reset) return;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) begin
        ow[k] = mw[d][k];
        ov[k] = mv[d][k];
      end
      if (!ov[2] && mc[d] != 16'hFFFF) mc[d] = mc[d] + 16'd1;
      for (int k = 1; k < 3; k++) begin
        mw[d][k] = ow[k-1] & msk[d][k];
        mv[d][k] = ov[k-1];
      end
      if (flush_in) begin
        for (int k = 0; k < 2; k++) begin
          mw[d][k] = '0;
          mv[d][k] = 1'b0;
        end
      end else if (stall_in) begin
        mw[d][1] = '0;
        mv[d][1] = 1'b0;
      end else if (valid_in && !nop_sel) begin
        mw[d][0] = ctrl_in & msk[d][0];
        mv[d][0] = 1'b1;
      end else begin
        mw[d][0] = '0;
        mv[d][0] = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "/ctrl_out"}, 32'(ctrl_out[d]), 32'({mw[d][2], mw[d][1], mw[d][0]}));
      chk({tag, "/valid_out"}, 32'(valid_out[d]), 32'({mv[d][2], mv[d][1], mv[d][0]}));
      chk({tag, "/bubble_cnt"}, 32'(bubble_cnt[d]), 32'(mc[d]));
      chk({tag, "/ready_out"}, 32'(ready_out[d]), 32'(!stall_in || flush_in));
    end
  endtask

  task automatic tick(input string tag, input bit do_check);
    @(posedge clk);
    model_step();
    #1;
    if (do_check) check_all(tag);
  endtask

  task automatic drive(input logic [7:0] c, input logic v, input logic n,
                       input logic s, input logic f);
    ctrl_in  = c;
    valid_in = v;
    nop_sel  = n;
    stall_in = s;
    flush_in = f;
  endtask

  initial begin
    msk[0][0] = 8'hFF; msk[0][1] = 8'hFF; msk[0][2] = 8'hFF;
    msk[1][0] = 8'hFF; msk[1][1] = 8'h0F; msk[1][2] = 8'hFF;
    model_reset();

    #2;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_hold");
    reset = 1'b1;

    // Three-word stream; A5 lands in stage 2 after the third edge
    drive(8'hA5, 1, 0, 0, 0); tick("stream1", 1);
    drive(8'h3C, 1, 0, 0, 0); tick("stream2", 1);
    chk("mask_stage1", 32'(ctrl_out[1][15:8]), 32'h05);
    drive(8'hFF, 1, 0, 0, 0); tick("stream3", 1);
    chk("stream_e3_s2", 32'(ctrl_out[0][23:16]), 32'hA5);
    chk("stream_e3_vld", 32'(valid_out[0]), 32'b111);
    chk("mask_stage2", 32'(ctrl_out[1][23:16]), 32'h05);
    drive(8'h00, 0, 0, 0, 0); tick("stream4", 1);
    chk("stream_e4_s2", 32'(ctrl_out[0][23:16]), 32'h3C);
    tick("stream5", 1);
    chk("stream_e5_s2", 32'(ctrl_out[0][23:16]), 32'hFF);

    // Two stall cycles with A5 held in stage 0
    drive(8'hA5, 1, 0, 0, 0); tick("stall_load", 1);
    drive(8'h77, 1, 1, 1, 0); #1;
    chk("stall_ready", 32'(ready_out[0]), 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick("stall", 1);
      chk("stall_s0", 32'(ctrl_out[0][7:0]), 32'hA5);
      chk("stall_s1", 32'(ctrl_out[0][15:8]), 32'h00);
      chk("stall_v1", 32'(valid_out[0][1]), 32'h0);
    end
    drive(8'h00, 0, 0, 0, 0); tick("stall_rel1", 1);
    tick("stall_rel2", 1);
    chk("stall_late_s2", 32'(ctrl_out[0][23:16]), 32'hA5);

    // Flush and stall together: flush wins
    drive(8'h33, 1, 0, 0, 0); tick("fl_fill", 1);
    drive(8'h22, 1, 0, 0, 0); tick("fl_fill", 1);
    drive(8'h11, 1, 0, 0, 0); tick("fl_fill", 1);
    drive(8'h99, 1, 0, 1, 1); tick("flush", 1);
    chk("flush_ctrl", 32'(ctrl_out[0]), 32'h220000);
    chk("flush_vld", 32'(valid_out[0]), 32'b100);

    // Asynchronous reset between edges with a full pipe
    drive(8'h44, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick("rst_fill", 1);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    tick("rst_held", 1);
    reset = 1'b1;
    drive(8'h5A, 1, 0, 0, 0); tick("post_rst", 1);
    chk("post_rst_s0", 32'(ctrl_out[0][7:0]), 32'h5A);

    for (int i = 0; i < 400; i++) begin
      drive(8'($urandom), ($urandom % 4) != 0, ($urandom % 8) == 0,
            ($urandom % 5) == 0, ($urandom % 8) == 0);
      tick("rand", 1);
    end

    // Counter saturation
    drive(8'h00, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1 model_reset();
    reset = 1'b1;
    for (int i = 0; i < 65540; i++) tick("long", 0);
    check_all("sat");
    chk("sat_cnt", 32'(bubble_cnt[0]), 32'hFFFF);
    drive(8'hC3, 1, 0, 0, 0); tick("sat_valid", 1);
    chk("sat_hold", 32'(bubble_cnt[0]), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
